// File: rtl/accel_sample_logger.sv
// Accelerometer sample logger: buffers 3-axis samples in a small FIFO and writes
// each one as two 32-bit words into a circular region of on-chip memory.
module accel_sample_logger #(
  parameter int ADDR_W     = 14,
  parameter int FIFO_DEPTH = 4,
  parameter int SEQ_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] buf_words,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [15:0]       s_x,
  input  logic [15:0]       s_y,
  input  logic [15:0]       s_z,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_chipselect,
  output logic              m_write,
  output logic [3:0]        m_byteenable,
  output logic [31:0]       m_writedata,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [7:0]        wrap_count,
  output logic [15:0]       drop_count,
  output logic              busy
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] ONE_A = ADDR_W'(1);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_W0, ST_W1} state_t;

  state_t            state_q, state_d;
  logic [47:0]       fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_idx_q, rd_idx_d, wr_idx_q, wr_idx_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              s_ready_q, s_ready_d;
  logic [47:0]       hold_q, hold_d;
  logic [ADDR_W-1:0] base_q, base_d, len_q, len_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [SEQ_W-1:0]  seq_q, seq_d;
  logic [7:0]        wrap_q, wrap_d;
  logic [15:0]       drop_q, drop_d;
  logic              m_write_q, m_write_d;
  logic [ADDR_W-1:0] m_address_q, m_address_d;
  logic [31:0]       m_writedata_q, m_writedata_d;

  logic [ADDR_W-1:0] len_eff;
  logic              fifo_empty, push, pop, drop_ev;

  // Bit 0 of buf_words is masked so the region always holds whole samples.
  assign len_eff    = buf_words & ~ONE_A;
  assign fifo_empty = (count_q == '0);
  assign push       = s_valid & s_ready_q & ~clear;
  assign drop_ev    = s_valid & enable & ~s_ready_q;

  always_comb begin
    state_d       = state_q;
    rd_idx_d      = rd_idx_q;
    wr_idx_d      = wr_idx_q;
    count_d       = count_q;
    hold_d        = hold_q;
    base_d        = base_q;
    len_d         = len_q;
    wr_ptr_d      = wr_ptr_q;
    seq_d         = seq_q;
    wrap_d        = wrap_q;
    drop_d        = drop_q;
    pop           = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && len_eff != '0) begin
          pop     = 1'b1;
          state_d = ST_W0;
        end
      end
      ST_W0: begin
        wr_ptr_d = wr_ptr_q + ONE_A;
        state_d  = ST_W1;
      end
      ST_W1: begin
        if (wr_ptr_q + ONE_A == len_q) begin
          wr_ptr_d = '0;
          if (wrap_q != 8'hFF) wrap_d = wrap_q + 8'd1;
        end else begin
          wr_ptr_d = wr_ptr_q + ONE_A;
        end
        seq_d = seq_q + SEQ_W'(1);
        if (!fifo_empty && len_eff != '0) begin
          pop     = 1'b1;
          state_d = ST_W0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A pop latches the config for this sample; a shrunk buffer restarts at offset 0.
    if (pop) begin
      hold_d   = fifo_mem_q[rd_idx_q];
      base_d   = base_addr;
      len_d    = len_eff;
      rd_idx_d = rd_idx_q + PTR_W'(1);
      if (wr_ptr_d >= len_eff) wr_ptr_d = '0;
    end

    if (push) wr_idx_d = wr_idx_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (drop_ev && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;

    // Outputs are registered, so they are computed from the next state.
    m_write_d     = (state_d != ST_IDLE);
    m_address_d   = '0;
    m_writedata_d = '0;
    if (state_d == ST_W0) begin
      m_address_d   = base_d + wr_ptr_d;
      m_writedata_d = hold_d[31:0];
    end else if (state_d == ST_W1) begin
      m_address_d   = base_d + wr_ptr_d;
      m_writedata_d = {seq_d[15:0], hold_d[47:32]};
    end

    s_ready_d = enable & (count_d < FULL_CNT);

    if (clear) begin
      state_d       = ST_IDLE;
      rd_idx_d      = '0;
      wr_idx_d      = '0;
      count_d       = '0;
      wr_ptr_d      = '0;
      seq_d         = '0;
      wrap_d        = '0;
      drop_d        = '0;
      m_write_d     = 1'b0;
      m_address_d   = '0;
      m_writedata_d = '0;
      s_ready_d     = enable;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_idx_q] <= {s_z, s_y, s_x};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      rd_idx_q      <= '0;
      wr_idx_q      <= '0;
      count_q       <= '0;
      s_ready_q     <= 1'b0;
      hold_q        <= '0;
      base_q        <= '0;
      len_q         <= '0;
      wr_ptr_q      <= '0;
      seq_q         <= '0;
      wrap_q        <= '0;
      drop_q        <= '0;
      m_write_q     <= 1'b0;
      m_address_q   <= '0;
      m_writedata_q <= '0;
    end else begin
      state_q       <= state_d;
      rd_idx_q      <= rd_idx_d;
      wr_idx_q      <= wr_idx_d;
      count_q       <= count_d;
      s_ready_q     <= s_ready_d;
      hold_q        <= hold_d;
      base_q        <= base_d;
      len_q         <= len_d;
      wr_ptr_q      <= wr_ptr_d;
      seq_q         <= seq_d;
      wrap_q        <= wrap_d;
      drop_q        <= drop_d;
      m_write_q     <= m_write_d;
      m_address_q   <= m_address_d;
      m_writedata_q <= m_writedata_d;
    end
  end

  assign s_ready      = s_ready_q;
  assign m_address    = m_address_q;
  assign m_chipselect = m_write_q;
  assign m_write      = m_write_q;
  assign m_byteenable = {4{m_write_q}};
  assign m_writedata  = m_writedata_q;
  assign wr_ptr       = wr_ptr_q;
  assign wrap_count   = wrap_q;
  assign drop_count   = drop_q;
  assign busy         = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_accel_sample_logger.sv
// Scoreboard bench for accel_sample_logger: expected memory writes are queued
// with the stimulus and a negedge monitor checks every write the DUT issues.
module tb_accel_sample_logger;

  logic        clk = 1'b0;
  logic        reset, enable, clear, s_valid;
  logic [13:0] base_addr, buf_words;
  logic [15:0] s_x, s_y, s_z;
  logic        s_ready, m_chipselect, m_write, busy;
  logic [13:0] m_address, wr_ptr;
  logic [3:0]  m_byteenable;
  logic [31:0] m_writedata;
  logic [7:0]  wrap_count;
  logic [15:0] drop_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int first_wr = -1;
  int last_wr = -1;
  logic [45:0] sb [$];

  accel_sample_logger dut (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear),
    .base_addr(base_addr), .buf_words(buf_words),
    .s_valid(s_valid), .s_ready(s_ready), .s_x(s_x), .s_y(s_y), .s_z(s_z),
    .m_address(m_address), .m_chipselect(m_chipselect), .m_write(m_write),
    .m_byteenable(m_byteenable), .m_writedata(m_writedata),
    .wr_ptr(wr_ptr), .wrap_count(wrap_count), .drop_count(drop_count), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every DUT write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && m_write) begin
      logic [45:0] e;
      checks++;
      if (first_wr < 0) first_wr = cyc;
      last_wr = cyc;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL write: unexpected write addr=%h data=%h", m_address, m_writedata);
      end else begin
        e = sb.pop_front();
        if (m_address !== e[45:32] || m_writedata !== e[31:0] ||
            m_byteenable !== 4'hF || m_chipselect !== 1'b1) begin
          errors++;
          $display("FAIL write: got addr=%h data=%h be=%h cs=%b expected addr=%h data=%h be=f cs=1",
                   m_address, m_writedata, m_byteenable, m_chipselect, e[45:32], e[31:0]);
        end else begin
          $display("write ok addr=%h data=%h", m_address, m_writedata);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end else begin
      $display("check ok %s = %0h", name, act);
    end
  endtask

  task automatic exp_wr(input logic [13:0] a, input logic [31:0] d);
    sb.push_back({a, d});
  endtask

  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    s_x = x; s_y = y; s_z = z; s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(); tick();
    chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
    chk("rst_m_write", {31'd0, m_write}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_wr_ptr", {18'd0, wr_ptr}, 32'd0);
    reset = 1'b0;
    tick();
    first_wr = -1;
    last_wr = -1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || m_write) && n < 200) begin
      tick();
      n++;
    end
    chk({name, "_idle_timeout"}, {31'd0, busy}, 32'd0);
    tick();
    chk({name, "_sb_empty"}, sb.size(), 32'd0);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; clear = 1'b0; s_valid = 1'b0;
    s_x = '0; s_y = '0; s_z = '0;
    base_addr = 14'h100; buf_words = 14'd8;

    // Test 1: single sample
    do_reset();
    exp_wr(14'h100, 32'h22221111);
    exp_wr(14'h101, 32'h00003333);
    send(16'h1111, 16'h2222, 16'h3333);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    wait_idle("t1");
    chk("t1_wr_ptr", {18'd0, wr_ptr}, 32'd2);

    // Test 2: 5 spaced samples, odd buf_words rounds down to 8
    buf_words = 14'd9;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      exp_wr(14'h100 + 14'((2 * i) % 8), {16'h0B00 + 16'(i), 16'h0A00 + 16'(i)});
      exp_wr(14'h101 + 14'((2 * i) % 8), {16'(i), 16'h0C00 + 16'(i)});
      send(16'h0A00 + 16'(i), 16'h0B00 + 16'(i), 16'h0C00 + 16'(i));
      wait_idle("t2");
    end
    chk("t2_wrap", {24'd0, wrap_count}, 32'd1);
    chk("t2_wr_ptr", {18'd0, wr_ptr}, 32'd2);

    // Test 3: 8 back-to-back samples into a 4-deep FIFO
    buf_words = 14'd8;
    do_reset();
    for (int k = 0; k < 7; k++) begin
      exp_wr(14'h100 + 14'((2 * k) % 8), {16'h3100 + 16'(k), 16'h3000 + 16'(k)});
      exp_wr(14'h101 + 14'((2 * k) % 8), {16'(k), 16'h3200 + 16'(k)});
    end
    for (int k = 0; k < 8; k++) begin
      s_x = 16'h3000 + 16'(k); s_y = 16'h3100 + 16'(k); s_z = 16'h3200 + 16'(k);
      s_valid = 1'b1;
      chk($sformatf("t3_s_ready_%0d", k), {31'd0, s_ready}, (k < 7) ? 32'd1 : 32'd0);
      tick();
    end
    s_valid = 1'b0;
    wait_idle("t3");
    chk("t3_drop", {16'd0, drop_count}, 32'd1);
    chk("t3_wrap", {24'd0, wrap_count}, 32'd1);
    chk("t3_write_span", last_wr - first_wr + 1, 32'd14);

    // Test 4: address wraps modulo 2^14
    base_addr = 14'h3FFE; buf_words = 14'd4;
    do_reset();
    exp_wr(14'h3FFE, 32'h00020001);
    exp_wr(14'h3FFF, 32'h00000003);
    exp_wr(14'h0000, 32'h00050004);
    exp_wr(14'h0001, 32'h00010006);
    send(16'h0001, 16'h0002, 16'h0003);
    send(16'h0004, 16'h0005, 16'h0006);
    wait_idle("t4");
    chk("t4_wrap", {24'd0, wrap_count}, 32'd1);
    chk("t4_wr_ptr", {18'd0, wr_ptr}, 32'd0);

    // Test 5: clear during W0 abandons word1
    base_addr = 14'h100; buf_words = 14'd8;
    do_reset();
    exp_wr(14'h100, 32'hBBBBAAAA);
    send(16'hAAAA, 16'hBBBB, 16'hCCCC);
    tick();
    chk("t5_in_w0", {31'd0, m_write}, 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t5_wr_ptr", {18'd0, wr_ptr}, 32'd0);
    chk("t5_wrap", {24'd0, wrap_count}, 32'd0);
    chk("t5_drop", {16'd0, drop_count}, 32'd0);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    tick();
    exp_wr(14'h100, 32'h56781234);
    exp_wr(14'h101, 32'h00009ABC);
    send(16'h1234, 16'h5678, 16'h9ABC);
    wait_idle("t5");

    // Test 6: zero-length buffer holds samples, then drains
    buf_words = 14'd0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      send(16'h6000 + 16'(i), 16'h6100 + 16'(i), 16'h6200 + 16'(i));
      tick();
    end
    tick(); tick();
    chk("t6_drop", {16'd0, drop_count}, 32'd2);
    chk("t6_busy", {31'd0, busy}, 32'd1);
    chk("t6_s_ready", {31'd0, s_ready}, 32'd0);
    chk("t6_no_write", {31'd0, m_write}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      exp_wr(14'h100 + 14'(2 * i), {16'h6100 + 16'(i), 16'h6000 + 16'(i)});
      exp_wr(14'h101 + 14'(2 * i), {16'(i), 16'h6200 + 16'(i)});
    end
    buf_words = 14'd8;
    wait_idle("t6");
    chk("t6_wr_ptr", {18'd0, wr_ptr}, 32'd0);
    chk("t6_wrap", {24'd0, wrap_count}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/accel_sample_logger.md
Name: accel_sample_logger

Overview:
- Upstream write-master for the NIOS on-chip memory. Captures 3-axis accelerometer samples from the SPI sensor interface.
- Buffers samples in a small FIFO, packs each sample into two 32-bit words and writes them into a circular region of the 16384×32 single-port memory, so software can read a rolling history.
- Drives the memory's write-side port directly: 14-bit word address, 4-bit byteenable, chipselect, write, 32-bit writedata. The memory has no waitrequest, so every write completes in 1 cycle.

Parameters:
- ADDR_W, 14, memory word-address width.
- FIFO_DEPTH, 4, input sample FIFO entries; power of 2, at least 2.
- SEQ_W, 16, sample sequence counter width; stored in the upper half of word1.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  logger enable.
- clear  in  1  synchronous soft clear, 1-cycle pulse.
- base_addr  in  ADDR_W  first word address of the circular buffer.
- buf_words  in  ADDR_W  buffer length in words; bit 0 ignored.
- s_valid  in  1  sample strobe; 1-cycle pulse per sample; the producer cannot stall.
- s_ready  out  1  FIFO can accept a sample.
- s_x, s_y, s_z  in  16 each  signed axis samples.
- m_address  out  ADDR_W  memory word address.
- m_chipselect  out  1  memory chipselect.
- m_write  out  1  memory write strobe.
- m_byteenable  out  4  memory byte enables.
- m_writedata  out  32  memory write data.
- wr_ptr  out  ADDR_W  offset of the next word to be written, relative to base.
- wrap_count  out  8  buffer wraps; saturates at 0xFF.
- drop_count  out  16  dropped samples; saturates at 0xFFFF.
- busy  out  1  FSM not in IDLE, or FIFO not empty.

Behaviour:
- Reset: all outputs 0, including s_ready and m_*. FIFO is emptied, sequence counter = 0, FSM goes to IDLE.
- Effective length L = {buf_words[ADDR_W-1:1], 1'b0}. When L == 0, the FSM does not pop; samples accumulate and then drop.
- s_ready:
  - s_ready = enable & !fifo_full, registered from the current count.
  - A pop in the same cycle does not free a slot for a push in that cycle.
- Push: s_valid & s_ready. The entry {z, y, x} is visible in the count the next cycle.
- Drop: s_valid & enable & !s_ready increments drop_count. While enable = 0, samples are ignored and not counted.
- FSM states and transitions:
  - IDLE: if fifo not empty and L != 0, pop the head into the holding register, latch base_addr and L, and go to W0.
    - If wr_ptr >= latched L at that point, set wr_ptr = 0 first; wrap_count is not incremented.
  - W0:
    - m_chipselect = m_write = 1, m_byteenable = 4'hF.
    - m_address = base + wr_ptr, modulo 2^ADDR_W.
    - m_writedata = {y, x}.
    - wr_ptr += 1; go to W1.
  - W1:
    - Write at base + wr_ptr with m_writedata = {seq[15:0], z}.
    - If wr_ptr + 1 == L: set wr_ptr = 0 and increment wrap_count. Otherwise wr_ptr += 1.
    - seq += 1.
    - If fifo not empty, pop (with the same latch/check as IDLE) and go to W0; otherwise go to IDLE.
- Throughput: 2 cycles per sample when back-to-back.
- m_* timing: registered outputs; write strobes are asserted during the W0/W1 state cycles only and are 0 in IDLE.
- Address wrap: address arithmetic wraps modulo 2^ADDR_W independently of L.
- clear:
  - Same effect as reset on the FIFO, FSM, wr_ptr, seq, wrap_count and drop_count.
  - An in-flight sample is abandoned: if asserted in W0, word1 is never written.
  - A push or drop in the clear cycle is discarded.
  - clear takes precedence over all simultaneous events.
- enable deassert mid-operation: the FSM finishes the current sample and drains the FIFO.
- Config latching: base_addr and buf_words are latched per sample at pop; changes take effect from the next sample.

Test Plan:
1. Reset, enable = 1, base = 0x100, buf_words = 8; one sample x = 0x1111, y = 0x2222, z = 0x3333 -> write at 0x100 with data 0x22221111, then next cycle write at 0x101 with data 0x00003333; wr_ptr = 2; busy returns to 0.
2. Same config, 5 spaced samples -> the 5th sample's words land at 0x100/0x101; word1 upper half = 0x0004; wrap_count = 1.
3. 8 samples on consecutive cycles, FIFO_DEPTH = 4 -> s_ready low in the 8th cycle; drop_count = 1; 7 samples written in order with seq 0..6; no gaps between writes.
4. base = 0x3FFE, buf_words = 4; 2 samples -> addresses 0x3FFE, 0x3FFF, 0x0000, 0x0001; then wrap_count = 1 and wr_ptr = 0.
5. clear asserted in the W0 cycle -> no W1 write; wr_ptr, wrap_count and drop_count are all 0; the next sample is written at base with seq 0.
6. buf_words = 0, 6 samples -> no memory writes; 4 samples held in the FIFO and drop_count = 2. Then set buf_words = 8 -> 4 samples written, seq 0..3.
